// File: rtl/dsp_ar_order_ctrl_if.sv
// Order-controller bus: AR-side record/stall and R-side select/disable.
// slave = the order controller, master = the AR/R dispatchers around it.
interface dsp_ar_order_ctrl_if #(
    parameter int SLV_AMT          = 2,
    parameter int TRANS_DATA_LEN_W = 8,
    parameter int MAX_OUTST        = 4
);
    localparam int SLV_ID_W = (SLV_AMT > 1) ? $clog2(SLV_AMT) : 1;
    localparam int CNT_W    = $clog2(MAX_OUTST) + 1;

    logic                        dsp_AR_hsk_i;
    logic [SLV_ID_W-1:0]         dsp_AR_slv_id_i;
    logic [TRANS_DATA_LEN_W-1:0] dsp_AR_len_i;
    logic                        dsp_AR_stall_o;
    logic                        dsp_RVALID_q1_i;
    logic                        dsp_RREADY_q1_i;
    logic [SLV_ID_W-1:0]         dsp_RDATA_slv_id_o;
    logic                        dsp_RDATA_disable_o;
    logic                        dsp_RDATA_last_o;
    logic [CNT_W-1:0]            outst_cnt_o;
    logic                        ord_ovf_o;

    modport slave (
        input  dsp_AR_hsk_i, dsp_AR_slv_id_i, dsp_AR_len_i,
        input  dsp_RVALID_q1_i, dsp_RREADY_q1_i,
        output dsp_AR_stall_o, dsp_RDATA_slv_id_o,
        output dsp_RDATA_disable_o, dsp_RDATA_last_o,
        output outst_cnt_o, ord_ovf_o
    );

    modport master (
        output dsp_AR_hsk_i, dsp_AR_slv_id_i, dsp_AR_len_i,
        output dsp_RVALID_q1_i, dsp_RREADY_q1_i,
        input  dsp_AR_stall_o, dsp_RDATA_slv_id_o,
        input  dsp_RDATA_disable_o, dsp_RDATA_last_o,
        input  outst_cnt_o, ord_ovf_o
    );
endinterface

// File: rtl/dsp_ar_order_ctrl.sv
// Read-ordering scheduler: records {slave,ARLEN} per accepted AR in issue
// order and steers the RDATA dispatcher to the oldest outstanding read.
// Ports: ACLK_i, ARESETn_i (async, active low), bus (slave modport).
module dsp_ar_order_ctrl #(
    parameter int SLV_AMT          = 2,
    parameter int TRANS_DATA_LEN_W = 8,
    parameter int MAX_OUTST        = 4
) (
    input  logic                 ACLK_i,
    input  logic                 ARESETn_i,
    dsp_ar_order_ctrl_if.slave   bus
);
    localparam int SLV_ID_W = (SLV_AMT > 1) ? $clog2(SLV_AMT) : 1;
    localparam int PTR_W    = $clog2(MAX_OUTST);
    localparam int PTR_AW   = PTR_W + 1;

    typedef struct packed {
        logic [SLV_ID_W-1:0]         slv_id;
        logic [TRANS_DATA_LEN_W-1:0] len;
    } ent_t;

    ent_t                        mem [MAX_OUTST];
    logic [PTR_AW-1:0]           wr_ptr;
    logic [PTR_AW-1:0]           rd_ptr;
    logic [TRANS_DATA_LEN_W-1:0] beat_cnt;
    logic                        ovf_q;

    logic full;
    logic empty;
    logic push;
    logic r_hsk;
    logic head_last;
    ent_t head;

    assign head  = mem[rd_ptr[PTR_W-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    // Same slot index, opposite lap: writer is one full lap ahead.
    assign full  = (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0])
                 & (wr_ptr[PTR_W] != rd_ptr[PTR_W]);

    // Full is judged on the current state, so a same-cycle pop never
    // frees room for the incoming AR.
    assign push      = bus.dsp_AR_hsk_i & ~full;
    assign r_hsk     = bus.dsp_RVALID_q1_i & bus.dsp_RREADY_q1_i & ~empty;
    assign head_last = (beat_cnt == head.len);

    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            beat_cnt <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < MAX_OUTST; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr[PTR_W-1:0]] <= '{
                    slv_id: bus.dsp_AR_slv_id_i,
                    len:    bus.dsp_AR_len_i
                };
                wr_ptr <= wr_ptr + PTR_AW'(1);
            end
            if (bus.dsp_AR_hsk_i && full) begin
                ovf_q <= 1'b1;
            end
            // Pop at beat==len, so ARLEN=255 retires before the counter wraps.
            if (r_hsk) begin
                if (head_last) begin
                    rd_ptr   <= rd_ptr + PTR_AW'(1);
                    beat_cnt <= '0;
                end else begin
                    beat_cnt <= beat_cnt + TRANS_DATA_LEN_W'(1);
                end
            end
        end
    end

    assign bus.dsp_AR_stall_o      = full;
    assign bus.dsp_RDATA_disable_o = empty;
    assign bus.dsp_RDATA_slv_id_o  = empty ? '0 : head.slv_id;
    assign bus.dsp_RDATA_last_o    = ~empty & head_last;
    assign bus.outst_cnt_o         = wr_ptr - rd_ptr;
    assign bus.ord_ovf_o           = ovf_q;
endmodule

// File: tb/tb_dsp_ar_order_ctrl.sv
// Scoreboard bench for dsp_ar_order_ctrl: queue-based reference model,
// directed scenarios followed by randomized AR/R traffic.
module tb_dsp_ar_order_ctrl;
    localparam int MAXO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    dsp_ar_order_ctrl_if #(
        .SLV_AMT(2), .TRANS_DATA_LEN_W(8), .MAX_OUTST(MAXO)
    ) bus ();

    dsp_ar_order_ctrl #(
        .SLV_AMT(2), .TRANS_DATA_LEN_W(8), .MAX_OUTST(MAXO)
    ) dut (
        .ACLK_i(clk),
        .ARESETn_i(rst_n),
        .bus(bus)
    );

    typedef struct {
        int slv;
        int len;
    } ent_t;

    typedef struct {
        int dis;
        int slv;
        int last;
        int stall;
        int outst;
        int ovf;
    } exp_t;

    ent_t mq[$];
    int   m_beat;
    int   m_ovf;
    exp_t sb[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.dis   = (mq.size() == 0);
        e.slv   = (mq.size() != 0) ? mq[0].slv : 0;
        e.last  = (mq.size() != 0) && (m_beat == mq[0].len);
        e.stall = (mq.size() == MAXO);
        e.outst = mq.size();
        e.ovf   = m_ovf;
        return e;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_beat = 0;
        m_ovf  = 0;
    endtask

    // Apply one clock of stimulus and advance the model across that edge.
    task automatic step(input bit hsk, input int slv, input int len,
                        input bit rv, input bit rr);
        bit   do_push;
        bit   do_pop;
        ent_t n;
        bus.dsp_AR_hsk_i    = hsk;
        bus.dsp_AR_slv_id_i = 1'(slv);
        bus.dsp_AR_len_i    = 8'(len);
        bus.dsp_RVALID_q1_i = rv;
        bus.dsp_RREADY_q1_i = rr;
        @(posedge clk);
        do_push = hsk && (mq.size() < MAXO);
        if (hsk && mq.size() == MAXO) m_ovf = 1;
        do_pop = 0;
        if (rv && rr && mq.size() > 0) begin
            if (m_beat == mq[0].len) begin
                do_pop = 1;
                m_beat = 0;
            end else begin
                m_beat++;
            end
        end
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
            n.slv = slv;
            n.len = len;
            mq.push_back(n);
        end
        sb.push_back(model_out());
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    task automatic beats(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 1, 1);
    endtask

    task automatic chk_now(input string tag);
        exp_t e;
        e = model_out();
        chk({tag, ".disable"}, int'(bus.dsp_RDATA_disable_o), e.dis);
        chk({tag, ".slv_id"}, int'(bus.dsp_RDATA_slv_id_o), e.slv);
        chk({tag, ".last"}, int'(bus.dsp_RDATA_last_o), e.last);
        chk({tag, ".stall"}, int'(bus.dsp_AR_stall_o), e.stall);
        chk({tag, ".outst"}, int'(bus.outst_cnt_o), e.outst);
        chk({tag, ".ovf"}, int'(bus.ord_ovf_o), e.ovf);
    endtask

    // Monitor: compares each post-edge expectation away from the edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("disable", int'(bus.dsp_RDATA_disable_o), e.dis);
            chk("slv_id", int'(bus.dsp_RDATA_slv_id_o), e.slv);
            chk("last", int'(bus.dsp_RDATA_last_o), e.last);
            chk("stall", int'(bus.dsp_AR_stall_o), e.stall);
            chk("outst", int'(bus.outst_cnt_o), e.outst);
            chk("ovf", int'(bus.ord_ovf_o), e.ovf);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        bus.dsp_AR_hsk_i    = 1'b0;
        bus.dsp_AR_slv_id_i = '0;
        bus.dsp_AR_len_i    = '0;
        bus.dsp_RVALID_q1_i = 1'b0;
        bus.dsp_RREADY_q1_i = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_now("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single burst slv1 len3.
        step(1, 1, 3, 0, 0);
        beats(4);
        idle(2);

        // Ordering with back-to-back heads.
        step(1, 0, 0, 0, 0);
        step(1, 1, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        beats(4);
        idle(2);

        // Fill, overflow, refused push during pop while full.
        for (int i = 0; i < MAXO; i++) step(1, i % 2, 0, 0, 0);
        step(1, 1, 5, 0, 0);
        step(1, 1, 7, 1, 1);
        beats(4);
        idle(2);

        // Asynchronous reset mid-burst with three entries.
        step(1, 1, 2, 0, 0);
        step(1, 0, 2, 0, 0);
        step(1, 1, 2, 1, 1);
        beats(1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_now("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // Concurrent push/pop at one outstanding entry.
        step(1, 0, 0, 0, 0);
        step(1, 1, 0, 1, 1);
        idle(1);
        beats(1);
        idle(1);

        // Maximum burst length.
        step(1, 1, 255, 0, 0);
        beats(256);
        idle(2);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) < 4, $urandom_range(0, 1),
                 ($urandom_range(0, 15) == 0) ? $urandom_range(0, 20)
                                              : $urandom_range(0, 3),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        end
        beats(120);
        idle(2);

        @(negedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end
endmodule
